// File: rtl/write_iq.sv
// write_iq: pops paired I/Q dequantized samples from two FWFT FIFOs, requantizes
// each to signed 16 bits (shift, optional round, saturate), packs {Q16,I16} and
// pushes the word to an output FIFO. Counts saturated channels, sticking at all-ones.
module write_iq #(
    parameter int QUANT_BITS = 10,
    parameter int ROUND      = 0,
    parameter int SAT_CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 inI_rd_en,
    input  logic                 inI_empty,
    input  logic [31:0]          inI_dout,
    output logic                 inQ_rd_en,
    input  logic                 inQ_empty,
    input  logic [31:0]          inQ_dout,
    output logic                 out_wr_en,
    input  logic                 out_full,
    output logic [31:0]          out_din,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam logic [0:0] S_READ  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    localparam logic signed [32:0] RND_BIAS =
        (ROUND != 0) ? (33'sd1 <<< (QUANT_BITS - 1)) : 33'sd0;

    // Returns {saturated, value16}; sum is 33 bits so the rounding bias cannot overflow.
    function automatic logic [16:0] requant(input logic [31:0] x);
        logic signed [32:0] sum;
        logic signed [32:0] t;
        sum = $signed({x[31], x}) + RND_BIAS;
        t   = sum >>> QUANT_BITS;
        if (t > 33'sd32767) begin
            return {1'b1, 16'h7FFF};
        end else if (t < -33'sd32768) begin
            return {1'b1, 16'h8000};
        end else begin
            return {1'b0, t[15:0]};
        end
    endfunction

    logic [0:0]           state_q, state_d;
    logic [31:0]          word_q, word_d;
    logic [SAT_CNT_W-1:0] sat_q, sat_d;
    logic [16:0]          req_i, req_q;
    logic [SAT_CNT_W:0]   sat_sum;
    logic                 pop, push;

    // Handshakes: gated by reset so nothing fires while the block is held in reset.
    always_comb begin
        pop  = reset && (state_q == S_READ) && !inI_empty && !inQ_empty;
        push = reset && (state_q == S_WRITE) && !out_full;
    end

    assign inI_rd_en = pop;
    assign inQ_rd_en = pop;
    assign out_wr_en = push;
    assign out_din   = word_q;
    assign sat_count = sat_q;

    // Requantize both channels and form the saturating counter increment.
    always_comb begin
        req_i   = requant(inI_dout);
        req_q   = requant(inQ_dout);
        sat_sum = {1'b0, sat_q}
                + {{SAT_CNT_W{1'b0}}, req_i[16]}
                + {{SAT_CNT_W{1'b0}}, req_q[16]};
    end

    // Next-state: capture word on pop, return to read once the word is accepted.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sat_d   = sat_q;
        if (pop) begin
            state_d = S_WRITE;
            word_d  = {req_q[15:0], req_i[15:0]};
            sat_d   = sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
        end
        if (push) begin
            state_d = S_READ;
        end
    end

    // State registers; reset discards any pending word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_READ;
            word_q  <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_write_iq.sv
// tb_write_iq: randomized and directed checks of write_iq against a transaction-level
// model (FIFO queues, pending-word scoreboard, arithmetic requantizer).
module tb_write_iq;

    localparam int QB = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic        inI_empty, inQ_empty, out_full;
    logic [31:0] inI_dout, inQ_dout;
    logic        inI_rd_en, inQ_rd_en, out_wr_en;
    logic [31:0] out_din;
    logic [15:0] sat_count;
    logic        inI_rd_en1, inQ_rd_en1, out_wr_en1;
    logic [31:0] out_din1;
    logic [2:0]  sat_count1;

    always #5 clock = ~clock;

    write_iq #(.QUANT_BITS(QB), .ROUND(0), .SAT_CNT_W(16)) dut0 (
        .clock(clock), .reset(reset),
        .inI_rd_en(inI_rd_en), .inI_empty(inI_empty), .inI_dout(inI_dout),
        .inQ_rd_en(inQ_rd_en), .inQ_empty(inQ_empty), .inQ_dout(inQ_dout),
        .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
        .sat_count(sat_count)
    );

    write_iq #(.QUANT_BITS(QB), .ROUND(1), .SAT_CNT_W(3)) dut1 (
        .clock(clock), .reset(reset),
        .inI_rd_en(inI_rd_en1), .inI_empty(inI_empty), .inI_dout(inI_dout),
        .inQ_rd_en(inQ_rd_en1), .inQ_empty(inQ_empty), .inQ_dout(inQ_dout),
        .out_wr_en(out_wr_en1), .out_full(out_full), .out_din(out_din1),
        .sat_count(sat_count1)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] qi[$], qq[$];
    logic [31:0] exp0[$], exp1[$];
    int          orig_i[$], orig_q[$];
    longint      sat0 = 0, sat1 = 0;
    bit          force_ie = 0, force_qe = 0, full_ctl = 0, rt_mode = 0;
    logic [31:0] last_word0, last_word1;
    int          wr_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Floor/round shift then clamp, done with plain 64-bit arithmetic.
    function automatic logic [15:0] rq(input logic [31:0] x, input bit rnd, output bit sat);
        longint v;
        v   = longint'($signed(x));
        sat = 0;
        if (rnd) v = v + (64'sd1 << (QB - 1));
        v = v >>> QB;
        if (v > 32767) begin
            v = 32767;
            sat = 1;
        end else if (v < -32768) begin
            v = -32768;
            sat = 1;
        end
        return v[15:0];
    endfunction

    task automatic push_pair(input logic [31:0] i, input logic [31:0] q);
        qi.push_back(i);
        qq.push_back(q);
    endtask

    // One clock: drive, check at mid-cycle, then apply model updates at the edge.
    task automatic tick();
        logic rd, wr, pending, exp_rd, exp_wr;
        logic [31:0] obs0, obs1;
        logic [15:0] i0, q0, i1, q1;
        bit si0, sq0, si1, sq1;
        inI_empty = force_ie || (qi.size() == 0);
        inQ_empty = force_qe || (qq.size() == 0);
        inI_dout  = (qi.size() != 0) ? qi[0] : $urandom();
        inQ_dout  = (qq.size() != 0) ? qq[0] : $urandom();
        out_full  = full_ctl;
        #3;
        pending = (exp0.size() != 0);
        exp_rd  = reset && !pending && !inI_empty && !inQ_empty;
        exp_wr  = reset && pending && !out_full;
        check_val("rdI", 32'(inI_rd_en), 32'(exp_rd));
        check_val("rdQ", 32'(inQ_rd_en), 32'(exp_rd));
        check_val("wr", 32'(out_wr_en), 32'(exp_wr));
        check_val("rd_r1", 32'({inI_rd_en1, inQ_rd_en1}), 32'({exp_rd, exp_rd}));
        check_val("wr_r1", 32'(out_wr_en1), 32'(exp_wr));
        if (pending) begin
            check_val("din0", out_din, exp0[0]);
            check_val("din1", out_din1, exp1[0]);
        end
        check_val("sat0", 32'(sat_count), 32'(sat0));
        check_val("sat1", 32'(sat_count1), 32'(sat1));
        rd = inI_rd_en;
        wr = out_wr_en;
        obs0 = out_din;
        obs1 = out_din1;
        @(posedge clock);
        if (rd && qi.size() != 0) begin
            i0 = rq(qi[0], 0, si0);
            q0 = rq(qq[0], 0, sq0);
            i1 = rq(qi[0], 1, si1);
            q1 = rq(qq[0], 1, sq1);
            exp0.push_back({q0, i0});
            exp1.push_back({q1, i1});
            orig_i.push_back(int'(qi[0]));
            orig_q.push_back(int'(qq[0]));
            sat0 = sat0 + si0 + sq0;
            if (sat0 > 65535) sat0 = 65535;
            sat1 = sat1 + si1 + sq1;
            if (sat1 > 7) sat1 = 7;
            void'(qi.pop_front());
            void'(qq.pop_front());
        end
        if (wr && pending) begin
            last_word0 = obs0;
            last_word1 = obs1;
            wr_cnt++;
            if (rt_mode) begin
                check_val("rt_I", 32'(int'($signed(obs0[15:0])) <<< QB), 32'(orig_i[0]));
                check_val("rt_Q", 32'(int'($signed(obs0[31:16])) <<< QB), 32'(orig_q[0]));
            end
            void'(exp0.pop_front());
            void'(exp1.pop_front());
            void'(orig_i.pop_front());
            void'(orig_q.pop_front());
        end
        #1;
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while ((qi.size() != 0 || exp0.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        check_val(tag, 32'(qi.size() + exp0.size()), 32'd0);
    endtask

    task automatic clear_model();
        exp0.delete(); exp1.delete(); orig_i.delete(); orig_q.delete();
        sat0 = 0; sat1 = 0;
    endtask

    initial begin
        int k, kq, wb;
        reset = 1'b0;
        inI_empty = 1'b1; inQ_empty = 1'b1; out_full = 1'b0;
        inI_dout = '0; inQ_dout = '0;
        @(posedge clock); #1;

        // Reset state, with a pair already available: nothing may be popped.
        push_pair(32'd1024, -32'sd2048);
        tick(); tick();
        check_val("rst_din0", out_din, 32'h0);
        check_val("rst_din1", out_din1, 32'h0);
        reset = 1'b1;

        // Test 1
        drain("t1_drain", 20);
        check_val("t1_word", last_word0, 32'hFFFE_0001);
        check_val("t1_sat", 32'(sat_count), 32'd0);
        check_val("t1_wcnt", 32'(wr_cnt), 32'd1);

        // Test 2
        push_pair(32'h7FFF_FFFF, 32'h8000_0000);
        drain("t2_drain", 20);
        check_val("t2_word", last_word0, 32'h8000_7FFF);
        check_val("t2_sat", 32'(sat_count), 32'd2);
        check_val("t2_word_r1", last_word1, 32'h8000_7FFF);

        // Test 3
        push_pair(32'hFFFF_FFFF, 32'd1536);
        drain("t3_drain", 20);
        check_val("t3_r0", last_word0, 32'h0001_FFFF);
        check_val("t3_r1", last_word1, 32'h0002_0000);

        // Test 4a: stall five cycles with a second pair ready.
        full_ctl = 1;
        push_pair(32'd4096, 32'd8192);
        push_pair(32'd1024, 32'd1024);
        tick();
        check_val("t4_pending", 32'(exp0.size()), 32'd1);
        for (int c = 0; c < 5; c++) tick();
        full_ctl = 0;
        wb = wr_cnt;
        tick();
        check_val("t4_first_write", 32'(wr_cnt - wb), 32'd1);
        check_val("t4_word", last_word0, 32'h0008_0004);
        drain("t4_drain", 20);

        // Test 4b: Q FIFO empty holds off popping.
        force_qe = 1;
        push_pair(32'd2048, 32'd2048);
        for (int c = 0; c < 3; c++) tick();
        check_val("t4_qempty", 32'(qi.size()), 32'd1);
        force_qe = 0;
        drain("t4b_drain", 20);

        // Test 5: reset while stalled in write.
        full_ctl = 1;
        push_pair(32'd5120, 32'd5120);
        push_pair(32'd2048, 32'd3072);
        tick();
        reset = 1'b0;
        #1;
        check_val("t5_din", out_din, 32'h0);
        check_val("t5_hs", 32'({inI_rd_en, inQ_rd_en, out_wr_en}), 32'd0);
        check_val("t5_sat", 32'(sat_count), 32'd0);
        clear_model();
        tick(); tick();
        reset = 1'b1;
        full_ctl = 0;
        drain("t5_drain", 20);
        check_val("t5_fresh", last_word0, 32'h0003_0002);

        // Test 6: round trip of k*1024 with random flow control.
        rt_mode = 1;
        for (int n = 0; n < 256; n++) begin
            k  = int'($urandom_range(0, 65535)) - 32768;
            kq = int'($urandom_range(0, 65535)) - 32768;
            push_pair(32'(k * 1024), 32'(kq * 1024));
        end
        for (int c = 0; c < 4000 && (qi.size() != 0 || exp0.size() != 0); c++) begin
            full_ctl = ($urandom_range(0, 3) == 0);
            force_ie = ($urandom_range(0, 5) == 0);
            force_qe = ($urandom_range(0, 5) == 0);
            tick();
        end
        force_ie = 0; force_qe = 0; full_ctl = 0;
        drain("t6_drain", 20);
        rt_mode = 0;

        // Arbitrary 32-bit samples, exercising saturation and counter sticking.
        for (int n = 0; n < 150; n++) push_pair($urandom(), $urandom());
        for (int c = 0; c < 3000 && (qi.size() != 0 || exp0.size() != 0); c++) begin
            full_ctl = ($urandom_range(0, 3) == 0);
            force_ie = ($urandom_range(0, 7) == 0);
            tick();
        end
        force_ie = 0; full_ctl = 0;
        drain("rand_drain", 20);
        check_val("sat1_stuck", 32'(sat_count1), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
